// File: rtl/lock_seq_ctrl.sv
// Keyed unlock sequencer: gates a protected FSM behind a multi-word key sequence,
// with per-word timeout, failure counting and a timed lockout after repeated failures.
module lock_seq_ctrl #(
    parameter int KEY_W       = 8,
    parameter int SEQ_LEN     = 4,
    parameter logic [KEY_W*SEQ_LEN-1:0] KEY_SEQ = 32'hD20F3CA5,
    parameter int TIMEOUT     = 16,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_in,
    input  logic             relock,
    output logic             key_ready,
    output logic             unlocked,
    output logic             fail_pulse,
    output logic             lockout,
    output logic [2:0]       key_idx,
    output logic [1:0]       fail_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(LOCKOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] L_LAST   = LW'(LOCKOUT_CYC - 1);
    localparam logic [2:0]    IDX_LAST = 3'(SEQ_LEN - 1);
    localparam logic [1:0]    F_MAX    = 2'(MAX_FAIL);

    typedef enum logic [2:0] {
        IDLE, CHECK, UNLOCKED, FAIL, LOCKOUT
    } state_t;

    state_t           state, state_n;
    logic [2:0]       idx_n;
    logic [1:0]       fcnt_n;
    logic [TW-1:0]    tcnt, tcnt_n;
    logic [LW-1:0]    lcnt, lcnt_n;
    logic [KEY_W-1:0] expected;

    // Outputs are flopped from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            key_idx    <= '0;
            fail_cnt   <= '0;
            tcnt       <= '0;
            lcnt       <= '0;
            key_ready  <= 1'b0;
            unlocked   <= 1'b0;
            fail_pulse <= 1'b0;
            lockout    <= 1'b0;
        end else begin
            state      <= state_n;
            key_idx    <= idx_n;
            fail_cnt   <= fcnt_n;
            tcnt       <= tcnt_n;
            lcnt       <= lcnt_n;
            key_ready  <= (state_n == CHECK);
            unlocked   <= (state_n == UNLOCKED);
            fail_pulse <= (state_n == FAIL);
            lockout    <= (state_n == LOCKOUT);
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = key_idx;
        fcnt_n   = fail_cnt;
        tcnt_n   = tcnt;
        lcnt_n   = lcnt;
        expected = KEY_SEQ[int'(key_idx)*KEY_W +: KEY_W];
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CHECK;
                    idx_n   = '0;
                    tcnt_n  = '0;
                end
            end
            CHECK: begin
                if (key_valid && key_in == expected) begin
                    tcnt_n = '0;
                    if (key_idx == IDX_LAST) begin
                        state_n = UNLOCKED;
                        fcnt_n  = '0;
                    end else begin
                        idx_n = key_idx + 3'd1;
                    end
                end else if (key_valid || tcnt == T_LAST) begin
                    // Wrong word or idle too long; the count is bumped on entry so
                    // FAIL can decide between IDLE and LOCKOUT from the new value.
                    state_n = FAIL;
                    fcnt_n  = (fail_cnt < F_MAX) ? fail_cnt + 2'd1 : fail_cnt;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            FAIL: begin
                state_n = (fail_cnt == F_MAX) ? LOCKOUT : IDLE;
                lcnt_n  = '0;
            end
            LOCKOUT: begin
                if (lcnt == L_LAST) begin
                    state_n = IDLE;
                    fcnt_n  = '0;
                    lcnt_n  = '0;
                end else begin
                    lcnt_n = lcnt + 1'b1;
                end
            end
            UNLOCKED: begin
                if (relock) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
